// File: rtl/pwm_duty_decoder_if.sv
// Duty decoder bus: enable and PWM line in,
// decoded duty word with valid/error flags out.
interface pwm_duty_decoder_if #(
  parameter int WIDTH = 6
);
  logic             Enable_SW_1;
  logic             pwm_in;
  logic [WIDTH-1:0] Duty_Output;
  logic             duty_valid;
  logic             period_err;

  modport master (
    output Enable_SW_1,
    output pwm_in,
    input  Duty_Output,
    input  duty_valid,
    input  period_err
  );

  modport slave (
    input  Enable_SW_1,
    input  pwm_in,
    output Duty_Output,
    output duty_valid,
    output period_err
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty word from a fixed-period PWM line,
// publishing one word per measured period plus an error flag.
module pwm_duty_decoder #(
  parameter int WIDTH         = 6,
  parameter int PRESCALE_LOG2 = 0
) (
  input logic               sysclk,
  input logic               reset,
  pwm_duty_decoder_if.slave bus
);
  localparam int CW = WIDTH + PRESCALE_LOG2 + 1;

  localparam logic [CW-1:0] ONE =
    {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] PERIOD =
    {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] TIMEOUT =
    PERIOD + (PERIOD >> 1);
  localparam logic [WIDTH-1:0] DMAX = '1;
  localparam logic [CW-1:0] DMAX_W =
    {{(CW-WIDTH){1'b0}}, DMAX};

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t state, state_n;

  logic             s1, pwm_s, prev;
  logic [1:0]       warm;
  logic [CW-1:0]    hi_cnt, hi_n;
  logic [CW-1:0]    per_cnt, per_n;
  logic [WIDTH-1:0] duty_q, duty_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;
  logic             warm_ok, rise, fall;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] x
  );
    return (x == '1) ? x : x + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_duty(
    input logic [CW-1:0] h
  );
    logic [CW-1:0] s;
    s = h >> PRESCALE_LOG2;
    if (s > DMAX_W) return DMAX;
    return s[WIDTH-1:0];
  endfunction

  // Edges stay blind until the sync chain holds real
  // samples, so a line already high at reset is not a rise.
  assign warm_ok = (warm == 2'd3);
  assign rise    = warm_ok & pwm_s & ~prev;
  assign fall    = warm_ok & ~pwm_s & prev;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      pwm_s   <= 1'b0;
      prev    <= 1'b0;
      warm    <= 2'd0;
      state   <= S_IDLE;
      hi_cnt  <= '0;
      per_cnt <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1      <= bus.pwm_in;
      pwm_s   <= s1;
      prev    <= pwm_s;
      warm    <= warm_ok ? warm : warm + 2'd1;
      state   <= state_n;
      hi_cnt  <= hi_n;
      per_cnt <= per_n;
      duty_q  <= duty_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    per_n   = sat_inc(per_cnt);
    hi_n    = hi_cnt;
    duty_n  = duty_q;
    valid_n = 1'b0;
    err_n   = err_q;
    if (!bus.Enable_SW_1) begin
      state_n = S_IDLE;
      per_n   = '0;
      hi_n    = '0;
      duty_n  = '0;
      err_n   = 1'b0;
    end else if (per_cnt == TIMEOUT) begin
      state_n = S_IDLE;
      per_n   = '0;
      hi_n    = '0;
      duty_n  = pwm_s ? DMAX : '0;
      err_n   = 1'b1;
      valid_n = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            state_n = S_HIGH;
            per_n   = ONE;
            hi_n    = ONE;
          end
        end
        S_HIGH: begin
          if (fall) state_n = S_LOW;
          else if (pwm_s) hi_n = sat_inc(hi_cnt);
        end
        S_LOW: begin
          if (rise) begin
            duty_n  = clamp_duty(hi_cnt);
            err_n   = (per_cnt != PERIOD);
            valid_n = 1'b1;
            per_n   = ONE;
            hi_n    = ONE;
            state_n = S_HIGH;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.Duty_Output = duty_q;
  assign bus.duty_valid  = valid_q;
  assign bus.period_err  = err_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder at WIDTH=6,
// PRESCALE_LOG2=0 (period 64, timeout 96).
module tb_pwm_duty_decoder;
  localparam int W = 6;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  pwm_duty_decoder_if #(.WIDTH(W)) bus ();

  pwm_duty_decoder #(
    .WIDTH(W),
    .PRESCALE_LOG2(0)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;

  int         vcnt = 0;
  logic [W-1:0] last_duty = '0;
  logic       last_err  = 1'b0;

  always @(negedge sysclk) begin
    if (bus.duty_valid === 1'b1) begin
      vcnt      <= vcnt + 1;
      last_duty <= bus.Duty_Output;
      last_err  <= bus.period_err;
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // One PWM period; optionally checks publish latency.
  task automatic pwm_period(
    input int high,
    input int per,
    input bit chk,
    input int exp_duty
  );
    for (int i = 0; i < per; i++) begin
      bus.pwm_in = (i < high);
      step();
      if (chk && i < 3) begin
        n_tests++;
        if (bus.duty_valid !== 1'((i == 2))) begin
          n_fail++;
          $display("FAIL latency edge %0d: valid=%b want %b",
                   i, bus.duty_valid, (i == 2));
        end
      end
      if (chk && i == 2) begin
        n_tests++;
        if (bus.Duty_Output !== W'(exp_duty)) begin
          n_fail++;
          $display("FAIL latency duty: got %0d want %0d",
                   bus.Duty_Output, exp_duty);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.Enable_SW_1 = 1'b0;
    bus.pwm_in      = 1'b0;
    repeat (3) step();
    n_tests++;
    if (bus.Duty_Output !== '0 || bus.duty_valid !== 1'b0
        || bus.period_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: duty=%0d valid=%b err=%b want 0",
               bus.Duty_Output, bus.duty_valid, bus.period_err);
    end
    reset           = 1'b0;
    bus.Enable_SW_1 = 1'b1;
    repeat (4) step();
    n_tests++;
    if (vcnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d pulses want 0", vcnt);
    end
  endtask

  task automatic test_steady();
    int base;
    base = vcnt;
    repeat (4) pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (vcnt - base !== 3) begin
      n_fail++;
      $display("FAIL steady_count: %0d want 3", vcnt - base);
    end
    n_tests++;
    if (last_duty !== 6'd20 || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL steady: duty=%0d err=%b want 20/0",
               last_duty, last_err);
    end
    pwm_period(20, 64, 1'b1, 20);
  endtask

  task automatic test_sawtooth();
    int base;
    int prev;
    prev = 20;
    base = vcnt;
    for (int d = 1; d <= 63; d++) begin
      pwm_period(d, 64, 1'b0, 0);
      n_tests++;
      if (last_duty !== W'(prev) || last_err !== 1'b0) begin
        n_fail++;
        $display("FAIL saw d=%0d: duty=%0d err=%b want %0d/0",
                 d, last_duty, last_err, prev);
      end
      prev = d;
    end
    pwm_period(1, 64, 1'b0, 0);
    n_tests++;
    if (last_duty !== 6'd63 || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL saw_wrap63: duty=%0d err=%b want 63/0",
               last_duty, last_err);
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (last_duty !== 6'd1 || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL saw_wrap1: duty=%0d err=%b want 1/0",
               last_duty, last_err);
    end
    n_tests++;
    if (vcnt - base !== 65) begin
      n_fail++;
      $display("FAIL saw_count: %0d want 65", vcnt - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    base       = vcnt;
    bus.pwm_in = 1'b1;
    repeat (250) step();
    n_tests++;
    if (vcnt - base !== 3) begin
      n_fail++;
      $display("FAIL to_hi_count: %0d want 3", vcnt - base);
    end
    n_tests++;
    if (last_duty !== 6'd63 || last_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_hi: duty=%0d err=%b want 63/1",
               last_duty, last_err);
    end
    base       = vcnt;
    bus.pwm_in = 1'b0;
    repeat (250) step();
    n_tests++;
    if (vcnt - base < 2) begin
      n_fail++;
      $display("FAIL to_lo_count: %0d want >=2", vcnt - base);
    end
    n_tests++;
    if (last_duty !== 6'd0 || last_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_lo: duty=%0d err=%b want 0/1",
               last_duty, last_err);
    end
  endtask

  task automatic test_period_err();
    int base;
    base = vcnt;
    repeat (3) pwm_period(20, 70, 1'b0, 0);
    n_tests++;
    if (vcnt - base !== 2 || last_duty !== 6'd20
        || last_err !== 1'b1) begin
      n_fail++;
      $display("FAIL per70: n=%0d duty=%0d err=%b want 2/20/1",
               vcnt - base, last_duty, last_err);
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (last_duty !== 6'd20 || last_err !== 1'b1) begin
      n_fail++;
      $display("FAIL per70_last: duty=%0d err=%b want 20/1",
               last_duty, last_err);
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (last_duty !== 6'd20 || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL per64_back: duty=%0d err=%b want 20/0",
               last_duty, last_err);
    end
  endtask

  task automatic test_enable();
    int base;
    for (int i = 0; i < 10; i++) begin
      bus.pwm_in = 1'b1;
      step();
    end
    bus.Enable_SW_1 = 1'b0;
    step();
    n_tests++;
    if (bus.Duty_Output !== '0 || bus.duty_valid !== 1'b0
        || bus.period_err !== 1'b0) begin
      n_fail++;
      $display("FAIL disable: duty=%0d valid=%b err=%b want 0",
               bus.Duty_Output, bus.duty_valid, bus.period_err);
    end
    base = vcnt;
    for (int i = 11; i < 64; i++) begin
      bus.pwm_in = (i < 20);
      if (i == 40) bus.Enable_SW_1 = 1'b1;
      step();
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (vcnt !== base) begin
      n_fail++;
      $display("FAIL reenable_arm: %0d pulses want 0",
               vcnt - base);
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (vcnt - base !== 1 || last_duty !== 6'd20
        || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable: n=%0d duty=%0d err=%b want 1/20/0",
               vcnt - base, last_duty, last_err);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int i = 0; i < 10; i++) begin
      bus.pwm_in = 1'b1;
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.Duty_Output !== '0 || bus.duty_valid !== 1'b0
        || bus.period_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: duty=%0d valid=%b err=%b want 0",
               bus.Duty_Output, bus.duty_valid, bus.period_err);
    end
    #2;
    reset = 1'b0;
    base  = vcnt;
    for (int i = 10; i < 64; i++) begin
      bus.pwm_in = (i < 20);
      @(posedge sysclk);
      #1;
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (vcnt !== base) begin
      n_fail++;
      $display("FAIL reset_arm: %0d pulses want 0",
               vcnt - base);
    end
    pwm_period(20, 64, 1'b0, 0);
    n_tests++;
    if (vcnt - base !== 1 || last_duty !== 6'd20
        || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resume: n=%0d duty=%0d err=%b",
               vcnt - base, last_duty, last_err);
    end
  endtask

  initial begin
    bus.Enable_SW_1 = 1'b0;
    bus.pwm_in      = 1'b0;
    test_reset();
    test_steady();
    test_sawtooth();
    test_timeout();
    test_period_err();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
